wbm_spi_ctrl: RTL and testbench

- Wishbone-domain sequencer for the SPI slave receive path.
- Takes bytes crossing from the SPI clock domain over the req/ack toggle handshake and decodes them into one-command-at-a-time Wishbone classic master cycles.
- Read results go to the SPI transmit path over a valid/ready byte stream.
- Sits between the SPI RX/TX crossings and the Wishbone interconnect.

---
 rtl/wbm_spi_pkg.sv | 18 +
 rtl/wbm_spi_ctrl_if.sv | 50 +++++
 rtl/clock_domain_import.sv | 37 +++
 rtl/wbm_spi_ctrl.sv | 156 +++++++++++++++
 tb/tb_wbm_spi_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbm_spi_pkg.sv
// Shared types and constants for the SPI-to-Wishbone command sequencer.
package wbm_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StWrite,
    StRead,
    StTx
  } state_e;

  localparam int unsigned CMD_WE_BIT  = 7;
  localparam int unsigned CMD_ADR_MSB = 6;

  // Returned to the TX path when a read is abandoned by the ack timeout.
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/wbm_spi_ctrl_if.sv
// Bundles the SPI RX handshake, Wishbone master bus and SPI TX byte stream of wbm_spi_ctrl.
interface wbm_spi_ctrl_if;

  logic       handshake_req;
  logic [7:0] handshake_data;
  logic       handshake_ack;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [6:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_ready;

  modport master (
    input  handshake_req,
    input  handshake_data,
    output handshake_ack,
    output wb_cyc_o,
    output wb_stb_o,
    output wb_we_o,
    output wb_adr_o,
    output wb_dat_o,
    input  wb_dat_i,
    input  wb_ack_i,
    output tx_data,
    output tx_stb,
    input  tx_ready
  );

  modport slave (
    output handshake_req,
    output handshake_data,
    input  handshake_ack,
    input  wb_cyc_o,
    input  wb_stb_o,
    input  wb_we_o,
    input  wb_adr_o,
    input  wb_dat_o,
    output wb_dat_i,
    output wb_ack_i,
    input  tx_data,
    input  tx_stb,
    output tx_ready
  );

endinterface

// File: rtl/clock_domain_import.sv
// Receives bytes from the SPI clock domain over a req/ack toggle handshake.
// A byte stays pending (ack withheld) until the consumer pulses consume_i.
module clock_domain_import (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [7:0] data_i,
  input  logic       consume_i,
  output logic       stb_o,
  output logic [7:0] data_o,
  output logic       ack_o
);

  logic [1:0] sync_q, sync_d;
  logic       ack_q, ack_d;

  always_comb begin
    sync_d = {sync_q[0], req_i};
    ack_d  = consume_i ? sync_q[1] : ack_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      ack_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      ack_q  <= ack_d;
    end
  end

  // data_i is held stable by the sender while req and ack differ.
  assign stb_o  = sync_q[1] ^ ack_q;
  assign data_o = data_i;
  assign ack_o  = ack_q;

endmodule

// File: rtl/wbm_spi_ctrl.sv
// Decodes SPI command bytes into single Wishbone classic cycles; read data goes to the TX stream.
// Optional macro WBM_SPI_CTRL_TIMEOUT_EN abandons a bus cycle after TIMEOUT cycles without ack.
module wbm_spi_ctrl
  import wbm_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  wbm_spi_ctrl_if.master bus
);

  logic       in_stb;
  logic       consume;
  logic [7:0] in_data;

  clock_domain_import u_import (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.handshake_req),
    .data_i   (bus.handshake_data),
    .consume_i(consume),
    .stb_o    (in_stb),
    .data_o   (in_data),
    .ack_o    (bus.handshake_ack)
  );

  state_e     state_q, state_d;
  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic [6:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_stb_q, tx_stb_d;

`ifdef WBM_SPI_CTRL_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timed_out;
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT, TIMEOUT_DATA};
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    tx_data_d = tx_data_q;
    tx_stb_d  = tx_stb_q;
    consume   = 1'b0;
`ifdef WBM_SPI_CTRL_TIMEOUT_EN
    // Zero outside the bus states, so every WRITE/READ entry starts from 0.
    cnt_d     = (state_q == StWrite || state_q == StRead) ? cnt_q + 8'd1 : 8'd0;
    timed_out = (cnt_q == 8'(TIMEOUT - 1));
`endif
    case (state_q)
      StIdle: begin
        if (in_stb) begin
          consume = 1'b1;
          adr_d   = in_data[CMD_ADR_MSB:0];
          if (in_data[CMD_WE_BIT]) begin
            state_d = StData;
          end else begin
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            state_d = StRead;
          end
        end
      end
      StData: begin
        if (in_stb) begin
          consume = 1'b1;
          dat_d   = in_data;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (bus.wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StIdle;
        end
`ifdef WBM_SPI_CTRL_TIMEOUT_EN
        else if (timed_out) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StIdle;
        end
`endif
      end
      StRead: begin
        if (bus.wb_ack_i) begin
          cyc_d     = 1'b0;
          tx_data_d = bus.wb_dat_i;
          tx_stb_d  = 1'b1;
          state_d   = StTx;
        end
`ifdef WBM_SPI_CTRL_TIMEOUT_EN
        else if (timed_out) begin
          cyc_d     = 1'b0;
          tx_data_d = TIMEOUT_DATA;
          tx_stb_d  = 1'b1;
          state_d   = StTx;
        end
`endif
      end
      StTx: begin
        if (bus.tx_ready) begin
          tx_stb_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 7'd0;
      dat_q     <= 8'd0;
      tx_data_q <= 8'd0;
      tx_stb_q  <= 1'b0;
`ifdef WBM_SPI_CTRL_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      tx_data_q <= tx_data_d;
      tx_stb_q  <= tx_stb_d;
`ifdef WBM_SPI_CTRL_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // cyc and stb share one flop so they can never disagree.
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_stb   = tx_stb_q;

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// Self-checking bench for wbm_spi_ctrl: scoreboard queues hold expected bus cycles and TX bytes.
module tb_wbm_spi_ctrl;

`ifdef WBM_SPI_CTRL_TIMEOUT_EN
  localparam int unsigned TbTimeout = 8;
`else
  localparam int unsigned TbTimeout = 255;
`endif

  typedef struct packed {
    logic       we;
    logic [6:0] adr;
    logic [7:0] dat;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wbm_spi_ctrl_if bus ();

  wbm_spi_ctrl #(
    .TIMEOUT(TbTimeout)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  wb_exp_t    exp_q[$];
  logic [7:0] tx_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic drive_byte(input logic [7:0] b);
    bus.handshake_data = b;
    bus.handshake_req  = ~bus.handshake_req;
  endtask

  // Toggles req on a falling edge and returns the falling edges until ack follows.
  task automatic send_byte(input logic [7:0] b, output int lat);
    @(negedge clk);
    drive_byte(b);
    lat = 0;
    while (bus.handshake_ack !== bus.handshake_req && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (bus.handshake_ack !== bus.handshake_req)
      $display("FAIL ack_toggle byte=%02h got ack=%b want %b", b, bus.handshake_ack,
               bus.handshake_req);
    else n_pass++;
  endtask

  // Waits for a bus cycle, checks it against the scoreboard, acks after delay cycles.
  task automatic wb_slave(input int delay, input logic [7:0] rdata);
    int      n;
    bit      held;
    wb_exp_t e;
    n = 0;
    while (bus.wb_cyc_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.wb_cyc_o !== 1'b1) $display("FAIL wb_cyc_start got=%b want 1", bus.wb_cyc_o);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL wb_scoreboard got empty queue want an entry");
      e = '0;
    end else begin
      e = exp_q.pop_front();
      n_pass++;
    end
    n_checks++;
    if ({bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o} !== {1'b1, e.we, e.adr})
      $display("FAIL wb_cmd got stb=%b we=%b adr=%02h want stb=1 we=%b adr=%02h",
               bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, e.we, e.adr);
    else n_pass++;
    if (e.we) begin
      n_checks++;
      if (bus.wb_dat_o !== e.dat)
        $display("FAIL wb_wdata got=%02h want=%02h", bus.wb_dat_o, e.dat);
      else n_pass++;
    end
    held = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1) held = 1'b0;
    end
    n_checks++;
    if (!held) $display("FAIL wb_hold got dropped want held %0d cycles", delay);
    else n_pass++;
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = rdata;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    n_checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 3'b000)
      $display("FAIL wb_end got cyc/stb/we=%b want 000",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o});
    else n_pass++;
  endtask

  // Waits for tx_stb, checks the byte, holds tx_ready low for hold cycles, then accepts.
  task automatic tx_accept(input int hold);
    int         n;
    bit         held;
    logic [7:0] e;
    n = 0;
    while (bus.tx_stb !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (tx_q.size() == 0) begin
      $display("FAIL tx_scoreboard got empty queue want an entry");
      e = 8'hxx;
    end else begin
      e = tx_q.pop_front();
      n_pass++;
    end
    n_checks++;
    if ({bus.tx_stb, bus.tx_data} !== {1'b1, e})
      $display("FAIL tx_byte got stb=%b data=%02h want stb=1 data=%02h", bus.tx_stb,
               bus.tx_data, e);
    else n_pass++;
    held = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.tx_stb !== 1'b1 || bus.tx_data !== e) held = 1'b0;
    end
    n_checks++;
    if (!held) $display("FAIL tx_hold got changed want held %0d cycles", hold);
    else n_pass++;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    n_checks++;
    if (bus.tx_stb !== 1'b0) $display("FAIL tx_release got stb=%b want 0", bus.tx_stb);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.handshake_ack, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o,
         bus.wb_dat_o, bus.tx_data, bus.tx_stb} !== 36'd0)
      $display("FAIL reset_outputs got ack=%b cyc=%b adr=%02h dat=%02h tx=%02h/%b want all 0",
               bus.handshake_ack, bus.wb_cyc_o, bus.wb_adr_o, bus.wb_dat_o, bus.tx_data,
               bus.tx_stb);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    int lat;
    send_byte(8'h85, lat);
    n_checks++;
    if (lat !== 3) $display("FAIL req_to_ack_latency got=%0d want=3", lat);
    else n_pass++;
    exp_q.push_back('{we: 1'b1, adr: 7'h05, dat: 8'h3C});
    send_byte(8'h3C, lat);
    n_checks++;
    if (lat !== 3 || bus.wb_stb_o !== 1'b1)
      $display("FAIL data_to_stb got lat=%0d stb=%b want lat=3 stb=1", lat, bus.wb_stb_o);
    else n_pass++;
    wb_slave(4, 8'h00);
  endtask

  task automatic test_read();
    int lat;
    exp_q.push_back('{we: 1'b0, adr: 7'h12, dat: 8'h00});
    tx_q.push_back(8'hA7);
    send_byte(8'h12, lat);
    wb_slave(4, 8'hA7);
    tx_accept(3);
  endtask

  task automatic test_back_pressure();
    int lat;
    bit withheld;
    exp_q.push_back('{we: 1'b0, adr: 7'h01, dat: 8'h00});
    tx_q.push_back(8'h5A);
    send_byte(8'h01, lat);
    wb_slave(2, 8'h5A);
    drive_byte(8'h82);
    withheld = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.handshake_ack === bus.handshake_req) withheld = 1'b0;
    end
    n_checks++;
    if (!withheld) $display("FAIL backpressure_ack got toggled want withheld during TX");
    else n_pass++;
    tx_accept(0);
    lat = 0;
    while (bus.handshake_ack !== bus.handshake_req && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (bus.handshake_ack !== bus.handshake_req)
      $display("FAIL backpressure_release got ack=%b want %b", bus.handshake_ack,
               bus.handshake_req);
    else n_pass++;
    exp_q.push_back('{we: 1'b1, adr: 7'h02, dat: 8'h11});
    send_byte(8'h11, lat);
    wb_slave(1, 8'h00);
  endtask

  task automatic test_reset_mid();
    int lat;
    send_byte(8'h81, lat);
    send_byte(8'h55, lat);
    #2;
    rst_n = 1'b0;
    bus.handshake_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.handshake_ack} !== 3'b000)
      $display("FAIL reset_mid got cyc/stb/ack=%b want 000",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.handshake_ack});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{we: 1'b1, adr: 7'h01, dat: 8'h55});
    send_byte(8'h81, lat);
    send_byte(8'h55, lat);
    wb_slave(2, 8'h00);
  endtask

  task automatic test_single_cycle();
    int         lat;
    int         n_stb;
    int         n_tx;
    logic [7:0] tx_seen;
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 8'hC3;
    bus.tx_ready = 1'b1;
    send_byte(8'h80, lat);
    send_byte(8'h00, lat);
    n_checks++;
    if ({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== {1'b1, 7'h00, 8'h00})
      $display("FAIL single_write_cmd got we=%b adr=%02h dat=%02h want 1/00/00",
               bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o);
    else n_pass++;
    n_stb = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.wb_stb_o === 1'b1) n_stb++;
      @(negedge clk);
    end
    n_checks++;
    if (n_stb !== 1) $display("FAIL single_write_stb got=%0d cycles want=1", n_stb);
    else n_pass++;
    send_byte(8'h33, lat);
    n_stb   = 0;
    n_tx    = 0;
    tx_seen = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (bus.wb_stb_o === 1'b1) n_stb++;
      if (bus.tx_stb === 1'b1) begin
        n_tx++;
        tx_seen = bus.tx_data;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({n_stb, n_tx, tx_seen} !== {32'd1, 32'd1, 8'hC3})
      $display("FAIL single_read got stb=%0d tx_stb=%0d data=%02h want 1/1/c3", n_stb, n_tx,
               tx_seen);
    else n_pass++;
    bus.wb_ack_i = 1'b0;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int lat;
    int n;
    send_byte(8'h7F, lat);
`ifdef WBM_SPI_CTRL_TIMEOUT_EN
    n = 0;
    while (bus.wb_cyc_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 8) $display("FAIL timeout_cycles got=%0d want=8", n);
    else n_pass++;
    tx_q.push_back(8'hFF);
    tx_accept(0);
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.wb_cyc_o === 1'b1) n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 1000) $display("FAIL no_timeout_cycles got=%0d want=1000", n);
    else n_pass++;
    exp_q.push_back('{we: 1'b0, adr: 7'h7F, dat: 8'h00});
    tx_q.push_back(8'h66);
    wb_slave(0, 8'h66);
    tx_accept(0);
`endif
  endtask

  initial begin
    bus.handshake_req  = 1'b0;
    bus.handshake_data = 8'h00;
    bus.wb_dat_i       = 8'h00;
    bus.wb_ack_i       = 1'b0;
    bus.tx_ready       = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_pressure();
    test_reset_mid();
    test_single_cycle();
    test_timeout();
    n_checks++;
    if (exp_q.size() + tx_q.size() != 0)
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size() + tx_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
